// File: rtl/video_cvbs_enc.sv
// video_cvbs_enc: 3-stage RGB-to-composite encoder (sync tip, blanking, burst, luma + modulated chroma).
// Optional VIDEO_CVBS_ENC_TESTBAR_EN adds an internal 8-colour vertical bar source.
module video_cvbs_enc #(
   parameter int C_SYNC_LV   = 16,
   parameter int C_BLANK_LV  = 72,
   parameter int C_BURST_AMP = 20
) (
   input  logic       CK_i,
   input  logic       XARST_i,
   input  logic       CK_EE_i,
   input  logic       RST_i,
   input  logic [2:0] RGB_i,
   input  logic       XBLK_i,
   input  logic       XSYNC_i,
   input  logic       COLOR_BAR_NOW_i,
   input  logic [2:0] CPHs_i,
`ifdef VIDEO_CVBS_ENC_TESTBAR_EN
   input  logic       TESTBAR_i,
   input  logic [9:0] HCTRs_i,
`endif
   output logic [7:0] CVBS_o
);
   typedef enum logic [1:0] {M_SYNC, M_BURST, M_BLANK, M_PIX} mode_t;

   localparam logic [9:0] SYNC_LV   = 10'(C_SYNC_LV);
   localparam logic [9:0] BLANK_LV  = 10'(C_BLANK_LV);
   localparam logic [6:0] BURST_AMP = 7'(C_BURST_AMP);

   mode_t              mode_d1, mode_n;
   logic [2:0]         rgb, cph_d1, hue_d1, hue_n, c_hue, ph;
   logic [7:0]         delta_d1, delta_n, c_delta, mag, sin_v;
   logic [6:0]         amp_d1, amp_n, c_amp;
   logic [9:0]         base_d2, base_n, sum;
   logic signed [13:0] prod;
   logic [7:0]         chroma_d2, chroma_n, cvbs_n;

`ifdef VIDEO_CVBS_ENC_TESTBAR_EN
   logic [2:0] bar;
   always_comb begin
      bar = 3'(HCTRs_i / 10'd80);
      // bar b shows colour ~{b[1],b[2],b[0]}, i.e. 7,6,3,2,5,4,1,0
      rgb = !TESTBAR_i ? RGB_i : HCTRs_i < 10'd640 ? ~{bar[1], bar[2], bar[0]} : 3'd0;
   end
`else
   assign rgb = RGB_i;
`endif

   always_comb begin
      {c_delta, c_amp, c_hue} = '0;
      case (rgb)
         3'd1:    {c_delta, c_amp, c_hue} = {8'd15,  7'd44, 3'd0};
         3'd2:    {c_delta, c_amp, c_hue} = {8'd75,  7'd58, 3'd5};
         3'd3:    {c_delta, c_amp, c_hue} = {8'd90,  7'd62, 3'd6};
         3'd4:    {c_delta, c_amp, c_hue} = {8'd38,  7'd62, 3'd2};
         3'd5:    {c_delta, c_amp, c_hue} = {8'd53,  7'd58, 3'd1};
         3'd6:    {c_delta, c_amp, c_hue} = {8'd113, 7'd44, 3'd4};
         3'd7:    {c_delta, c_amp, c_hue} = {8'd128, 7'd0,  3'd0};
         default: {c_delta, c_amp, c_hue} = '0;
      endcase
   end

   always_comb begin
      mode_n   = RST_i ? M_BLANK : !XSYNC_i ? M_SYNC : COLOR_BAR_NOW_i ? M_BURST : !XBLK_i ? M_BLANK : M_PIX;
      hue_n    = RST_i ? 3'd0 : mode_n == M_BURST ? 3'd4 : c_hue;
      amp_n    = mode_n == M_BURST ? BURST_AMP : mode_n == M_PIX ? c_amp : 7'd0;
      delta_n  = mode_n == M_PIX ? c_delta : 8'd0;
      ph       = cph_d1 + hue_d1;
      // sine magnitude by quarter position, sign from the half-cycle bit
      mag      = ph[1:0] == 2'd0 ? 8'd0 : ph[1:0] == 2'd2 ? 8'd64 : 8'd45;
      sin_v    = ph[2] ? -mag : mag;
      prod     = $signed({7'd0, amp_d1}) * $signed({{6{sin_v[7]}}, sin_v});
      chroma_n = RST_i ? 8'd0 : 8'(prod >>> 6);
      base_n   = RST_i || mode_d1 == M_BLANK || mode_d1 == M_BURST ? BLANK_LV :
                 mode_d1 == M_SYNC ? SYNC_LV : BLANK_LV + {2'd0, delta_d1};
      sum      = base_d2 + {{2{chroma_d2[7]}}, chroma_d2};
      cvbs_n   = RST_i ? BLANK_LV[7:0] : sum[9] ? 8'd0 : sum[8] ? 8'd255 : sum[7:0];
   end

   always_ff @(posedge CK_i or negedge XARST_i)
      if (!XARST_i) begin
         mode_d1   <= M_BLANK;
         cph_d1    <= 3'd0;
         hue_d1    <= 3'd0;
         amp_d1    <= 7'd0;
         delta_d1  <= 8'd0;
         base_d2   <= BLANK_LV;
         chroma_d2 <= 8'd0;
         CVBS_o    <= BLANK_LV[7:0];
      end else if (CK_EE_i) begin
         mode_d1   <= mode_n;
         cph_d1    <= RST_i ? 3'd0 : CPHs_i;
         hue_d1    <= hue_n;
         amp_d1    <= amp_n;
         delta_d1  <= delta_n;
         base_d2   <= base_n;
         chroma_d2 <= chroma_n;
         CVBS_o    <= cvbs_n;
      end
endmodule
